// File: rtl/aemb_dwb_sram.sv
// Data-wishbone responder for the AEMB data port: word-wide synchronous RAM
// with byte-lane writes and a registered ack after WS wait states.
module aemb_dwb_sram #(
    parameter int AW = 10,
    parameter int WS = 0
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        dwb_stb_i,
    input  logic        dwb_wre_i,
    input  logic [29:0] dwb_adr_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic [31:0] dwb_dat_i,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_ack_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] WS_LOAD = (WS > 0) ? 4'(WS - 1) : 4'd0;
    localparam bit         WS_ZERO = (WS == 0);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic          w_commit;

    logic [AW-1:0] r_adr;
    logic [3:0]    r_sel;
    logic          r_wre;
    logic [31:0]   r_dat;

    logic [AW-1:0] w_adr;
    logic [3:0]    w_sel;
    logic          w_wre;
    logic [31:0]   w_dat;

    logic          r_ack;
    logic [31:0]   r_rdat;
    logic [31:0]   r_mem [0:(2**AW)-1];

    // High address bits alias; they are intentionally not decoded.
    logic          w_unused;
    assign w_unused = ^dwb_adr_i[29:AW];

    // Zero-wait commits happen on the accepting edge, so use live inputs in IDLE.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_adr = dwb_adr_i[AW-1:0];
            w_sel = dwb_sel_i;
            w_wre = dwb_wre_i;
            w_dat = dwb_dat_i;
        end else begin
            w_adr = r_adr;
            w_sel = r_sel;
            w_wre = r_wre;
            w_dat = r_dat;
        end
    end

    // Next-state, wait counter and commit strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dwb_stb_i) begin
                    if (WS_ZERO) begin
                        w_state_nxt = ST_ACK;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = WS_LOAD;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!dwb_stb_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_ACK;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // FSM state, request latch, ack and read-data registers.
    always_ff @(posedge gclk) begin
        if (grst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_adr   <= '0;
            r_sel   <= 4'd0;
            r_wre   <= 1'b0;
            r_dat   <= 32'd0;
            r_ack   <= 1'b0;
            r_rdat  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_commit;
            if ((r_state == ST_IDLE) && dwb_stb_i) begin
                r_adr <= dwb_adr_i[AW-1:0];
                r_sel <= dwb_sel_i;
                r_wre <= dwb_wre_i;
                r_dat <= dwb_dat_i;
            end
            if (w_commit && !w_wre) begin
                r_rdat <= r_mem[w_adr];
            end
        end
    end

    // Byte-lane RAM write; contents survive reset.
    always_ff @(posedge gclk) begin
        if (!grst && w_commit && w_wre) begin
            for (int i = 0; i < 4; i++) begin
                if (w_sel[i]) begin
                    r_mem[w_adr][8*i +: 8] <= w_dat[8*i +: 8];
                end
            end
        end
    end

    assign dwb_ack_o = r_ack;
    assign dwb_dat_o = r_rdat;

endmodule
